data_mem_responder: RTL and testbench

Memory-side responder for the CPU data bus. It accepts load/store requests from the 16-bit RISC core over a valid/ready handshake and holds them for a programmable number of wait states. It then commits the access to an internal word-addressed RAM and returns a response that the CPU must acknowledge. It sits between `system_cpu_master`'s data port and data storage, and sources the word that reaches the CPU as `data_mem_to_cpu`.

---
 rtl/system_cpu_pkg.sv | 13 +
 rtl/dmem_array.sv | 30 +++
 rtl/data_mem_responder.sv | 107 ++++++++++
 tb/tb_data_mem_responder.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/system_cpu_pkg.sv
// Definitions shared between the 16-bit RISC core and its data-memory responder.
package system_cpu_pkg;

    localparam int SYS_DATA_W = 16;
    localparam int SYS_ADDR_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_state_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous RAM with registered read data and no reset.
module dmem_array #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // rdata only moves on an enabled access, so it holds between commits;
    // a write also presents the written word (store echo).
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
                rdata     <= wdata;
            end else begin
                rdata     <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-bus responder: accepts one load/store, waits WAIT_CYCLES, commits to RAM, holds the response.
module data_mem_responder
    import system_cpu_pkg::*;
#(
    parameter int DATA_W      = SYS_DATA_W,
    parameter int ADDR_W      = SYS_ADDR_W,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err
);

    localparam int              CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
    localparam bit              DIRECT   = (WAIT_CYCLES == 0);

    dmem_state_t       state, next_state;
    logic [CNT_W-1:0]  cnt;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              rdata_zero;
    logic              accept, commit, in_range;
    logic              cmt_we;
    logic [ADDR_W-1:0] cmt_addr;
    logic [DATA_W-1:0] cmt_wdata;
    logic [DATA_W-1:0] ram_rdata;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req_valid) next_state = DIRECT ? RESP : WAIT;
            WAIT:    if (cnt == '0) next_state = RESP;
            RESP:    if (resp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign accept = req_valid && req_ready;
    assign commit = (state != RESP) && (next_state == RESP);

    // With no wait states the commit coincides with the accept edge, so the
    // access is taken from the request inputs instead of the latched copy.
    assign cmt_we    = DIRECT ? req_we    : we_q;
    assign cmt_addr  = DIRECT ? req_addr  : addr_q;
    assign cmt_wdata = DIRECT ? req_wdata : wdata_q;
    assign in_range  = 32'(cmt_addr) < DEPTH;

    dmem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (clk),
        .en    (commit && in_range),
        .we    (cmt_we),
        .addr  (cmt_addr),
        .wdata (cmt_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            rdata_zero <= 1'b1;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state      <= next_state;
            req_ready  <= (next_state == IDLE);
            resp_valid <= (next_state == RESP);
            if (accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                cnt     <= CNT_LOAD;
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (commit) begin
                resp_err   <= !in_range;
                rdata_zero <= !in_range;
            end else if (state == RESP && resp_ready) begin
                resp_err <= 1'b0;
            end
        end
    end

    // RAM output register has no reset; the zero flag covers reset and errors.
    assign resp_rdata = rdata_zero ? '0 : ram_rdata;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed plus randomized checks of data_mem_responder against a word-level memory model.
module tb_data_mem_responder;

    localparam int DEP_A = 200;
    localparam int W_A   = 2;
    localparam int DEP_B = 256;
    localparam int W_B   = 0;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_we     [2];
    logic [7:0]  req_addr   [2];
    logic [15:0] req_wdata  [2];
    logic        resp_valid [2];
    logic        resp_ready [2];
    logic [15:0] resp_rdata [2];
    logic        resp_err   [2];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [15:0] mdl [2][256];
    bit          val [2][256];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_responder #(.DATA_W(16), .ADDR_W(8), .DEPTH(DEP_A), .WAIT_CYCLES(W_A)) u_dut_a (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
    );

    data_mem_responder #(.DATA_W(16), .ADDR_W(8), .DEPTH(DEP_B), .WAIT_CYCLES(W_B)) u_dut_b (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pick_addr();
        case ($urandom_range(0, 5))
            0:       return 8'h00;
            1:       return 8'h05;
            2:       return 8'hC7;
            3:       return 8'hC8;
            4:       return 8'hFF;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    // Entered and left on a falling edge. hold>0 stalls the response with
    // resp_ready low while req_valid stays high.
    task automatic do_req(input int sel, input bit we, input logic [7:0] addr,
                          input logic [15:0] wdata, input int hold, input bit scramble,
                          output int acc_cyc);
        int          dep, wc, lat;
        bit          err, known;
        logic [15:0] exp_rd, held_rd;
        dep = (sel == 0) ? DEP_A : DEP_B;
        wc  = (sel == 0) ? W_A : W_B;
        chk("req_ready_idle", req_ready[sel], 1'b1);
        req_valid[sel]  = 1'b1;
        req_we[sel]     = we;
        req_addr[sel]   = addr;
        req_wdata[sel]  = wdata;
        resp_ready[sel] = (hold == 0);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        if (hold == 0) req_valid[sel] = 1'b0;
        if (scramble) begin
            req_addr[sel]  = 8'($urandom);
            req_wdata[sel] = 16'($urandom);
            req_we[sel]    = 1'($urandom);
        end
        err    = int'(addr) >= dep;
        known  = err || we || val[sel][addr];
        exp_rd = err ? 16'h0000 : (we ? wdata : mdl[sel][addr]);
        if (!err && we) begin
            mdl[sel][addr] = wdata;
            val[sel][addr] = 1'b1;
        end
        @(negedge clk);
        lat = 0;
        while (!resp_valid[sel] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("resp_latency", lat, wc);
        chk("resp_err", resp_err[sel], err);
        if (known) chk("resp_rdata", resp_rdata[sel], exp_rd);
        held_rd = resp_rdata[sel];
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("stall_valid", resp_valid[sel], 1'b1);
            chk("stall_rdata", resp_rdata[sel], held_rd);
            chk("stall_err", resp_err[sel], err);
            chk("stall_req_ready", req_ready[sel], 1'b0);
        end
        req_valid[sel]  = 1'b0;
        resp_ready[sel] = 1'b1;
        @(negedge clk);
        chk("retire_valid", resp_valid[sel], 1'b0);
        chk("retire_err", resp_err[sel], 1'b0);
        chk("retire_req_ready", req_ready[sel], 1'b1);
        chk("retire_rdata_kept", resp_rdata[sel], held_rd);
    endtask

    initial begin
        int c0, c1;
        for (int s = 0; s < 2; s++) begin
            req_valid[s] = 1'b0; req_we[s] = 1'b0; req_addr[s] = '0;
            req_wdata[s] = '0;   resp_ready[s] = 1'b1;
        end
        repeat (2) @(negedge clk);
        chk("rst_req_ready", req_ready[0], 1'b1);
        chk("rst_resp_valid", resp_valid[0], 1'b0);
        chk("rst_resp_rdata", resp_rdata[0], 16'h0000);
        rst = 1'b1;
        @(negedge clk);

        // Store then load with wait states; spacing of accepts is WAIT_CYCLES+2.
        do_req(0, 1'b1, 8'h05, 16'hBEEF, 0, 1'b0, c0);
        do_req(0, 1'b0, 8'h05, 16'h0000, 0, 1'b0, c1);
        chk("throughput_a", c1 - c0, W_A + 2);

        // Stalled load response.
        do_req(0, 1'b0, 8'h05, 16'h0000, 5, 1'b0, c0);

        // Out-of-range accesses must leave the array untouched.
        do_req(0, 1'b1, 8'h00, 16'h1111, 0, 1'b0, c0);
        do_req(0, 1'b1, 8'hC7, 16'h2222, 0, 1'b0, c0);
        do_req(0, 1'b0, 8'hC8, 16'h0000, 0, 1'b0, c0);
        do_req(0, 1'b1, 8'hC8, 16'h1234, 0, 1'b0, c0);
        do_req(0, 1'b0, 8'h00, 16'h0000, 0, 1'b0, c0);
        do_req(0, 1'b0, 8'hC7, 16'h0000, 0, 1'b0, c0);

        // Request inputs changing after accept are ignored.
        do_req(0, 1'b1, 8'h21, 16'h5A5A, 0, 1'b1, c0);
        do_req(0, 1'b0, 8'h21, 16'h0000, 0, 1'b1, c0);

        // Reset during the wait of a store drops it.
        do_req(0, 1'b1, 8'h10, 16'h0000, 0, 1'b0, c0);
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 8'h10; req_wdata[0] = 16'hDEAD;
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("async_rst_req_ready", req_ready[0], 1'b1);
        chk("async_rst_resp_valid", resp_valid[0], 1'b0);
        chk("async_rst_resp_err", resp_err[0], 1'b0);
        chk("async_rst_resp_rdata", resp_rdata[0], 16'h0000);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        do_req(0, 1'b0, 8'h10, 16'h0000, 0, 1'b0, c0);

        // Zero wait states: back-to-back loads two cycles apart.
        do_req(1, 1'b1, 8'h00, 16'hA000, 0, 1'b0, c0);
        do_req(1, 1'b1, 8'h01, 16'hA001, 0, 1'b0, c0);
        do_req(1, 1'b0, 8'h00, 16'h0000, 0, 1'b0, c0);
        do_req(1, 1'b0, 8'h01, 16'h0000, 0, 1'b0, c1);
        chk("throughput_b", c1 - c0, W_B + 2);
        do_req(1, 1'b1, 8'hFF, 16'h7777, 1, 1'b0, c0);
        do_req(1, 1'b0, 8'hFF, 16'h0000, 0, 1'b0, c0);

        // Randomized traffic on both configurations.
        for (int s = 0; s < 2; s++) begin
            for (int n = 0; n < 30; n++) begin
                do_req(s, 1'($urandom), pick_addr(), 16'($urandom),
                       ($urandom_range(0, 3) == 0) ? 2 : 0, 1'($urandom), c0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
